// File: rtl/path_decision_out_pkg.sv
// Shared widths and payload types for the path decision output stage.
// Holds the candidate record {path, ped, idx} that moves through the compare
// tree and the output FIFO.
package path_decision_out_pkg;

  localparam int unsigned N        = 4;              // symbols per path
  localparam int unsigned SYM_WL   = 2;              // bits per symbol
  localparam int unsigned NUM_PATH = 4;              // surviving paths per result
  localparam int unsigned IDX_WL   = 2;              // path index width
  localparam int unsigned PATH_WL  = N * SYM_WL;     // one path
  localparam int unsigned PED_WL   = 16;             // one unsigned PED
  localparam int unsigned DEPTH    = 4;              // FIFO entries, power of 2
  localparam int unsigned PTR_WL   = $clog2(DEPTH);
  localparam int unsigned LVL_WL   = PTR_WL + 1;
  localparam int unsigned CNT_WL   = 8;              // drop counter, saturating

  typedef struct packed {
    logic [PATH_WL-1:0] path;
    logic [PED_WL-1:0]  ped;
    logic [IDX_WL-1:0]  idx;
  } cand_t;

endpackage

// File: rtl/path_decision_out_if.sv
// Handshake/data bundle for path_decision_out.
//   in_valid/path_in/ped_in : one detector result (4 paths + 4 PEDs)
//   out_ready/ovf_clr       : consumer accept and overflow clear
//   out_valid/out_path/out_ped/out_idx : FIFO head decision
//   fifo_level/ovf_sticky/drop_cnt     : occupancy and overflow status
// master = producer/consumer side, slave = the decision block.
interface path_decision_out_if;
  import path_decision_out_pkg::*;

  logic                         in_valid;
  logic [NUM_PATH*PATH_WL-1:0]  path_in;
  logic [NUM_PATH*PED_WL-1:0]   ped_in;
  logic                         out_ready;
  logic                         ovf_clr;
  logic                         out_valid;
  logic [PATH_WL-1:0]           out_path;
  logic [PED_WL-1:0]            out_ped;
  logic [IDX_WL-1:0]            out_idx;
  logic [LVL_WL-1:0]            fifo_level;
  logic                         ovf_sticky;
  logic [CNT_WL-1:0]            drop_cnt;

  modport master (
    output in_valid, path_in, ped_in, out_ready, ovf_clr,
    input  out_valid, out_path, out_ped, out_idx, fifo_level, ovf_sticky, drop_cnt
  );

  modport slave (
    input  in_valid, path_in, ped_in, out_ready, ovf_clr,
    output out_valid, out_path, out_ped, out_idx, fifo_level, ovf_sticky, drop_cnt
  );

endinterface

// File: rtl/path_decision_out_ped_min2.sv
// Combinational 2-input compare-select on {path, ped, idx}.
//   a, b : candidates
//   y_c  : candidate with the smaller unsigned PED; on a tie the lower idx wins
module path_decision_out_ped_min2
  import path_decision_out_pkg::*;
(
  input  cand_t a,
  input  cand_t b,
  output cand_t y_c
);

  always_comb begin
    y_c = a;
    if (b.ped < a.ped) begin
      y_c = b;
    end else if ((b.ped == a.ped) && (b.idx < a.idx)) begin
      y_c = b;
    end
  end

endmodule

// File: rtl/path_decision_out.sv
// Final MIMO detector stage: selects the minimum-PED path over a two-cycle
// compare tree, buffers the decision in a small FIFO and hands it out on a
// valid/ready port. The upstream pipeline never stalls, so a push into a full
// FIFO with no simultaneous pop is dropped and counted.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of path_decision_out_if (inputs, head decision, status)
module path_decision_out
  import path_decision_out_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  path_decision_out_if.slave  bus
);

  // Split the flat input buses into indexed candidates
  cand_t cand_c [NUM_PATH];

  always_comb begin
    for (int unsigned k = 0; k < NUM_PATH; k++) begin
      cand_c[k].path = bus.path_in[k*PATH_WL +: PATH_WL];
      cand_c[k].ped  = bus.ped_in[k*PED_WL +: PED_WL];
      cand_c[k].idx  = IDX_WL'(k);
    end
  end

  // Compare tree: pairs (0,1),(2,3) in S1, winners in S2
  cand_t w01_c, w23_c, best_c;
  cand_t s1_lo, s1_hi, s2;
  logic  v1, v2;

  path_decision_out_ped_min2 u_min01 (.a(cand_c[0]), .b(cand_c[1]), .y_c(w01_c));
  path_decision_out_ped_min2 u_min23 (.a(cand_c[2]), .b(cand_c[3]), .y_c(w23_c));
  path_decision_out_ped_min2 u_min_f (.a(s1_lo),     .b(s1_hi),     .y_c(best_c));

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      s1_lo <= '0;
      s1_hi <= '0;
      s2    <= '0;
    end else begin
      v1    <= bus.in_valid;
      v2    <= v1;
      s1_lo <= w01_c;
      s1_hi <= w23_c;
      s2    <= best_c;
    end
  end

  // Output FIFO state; the head entry is held in registers
  cand_t             mem [DEPTH];
  logic [PTR_WL-1:0] wr_ptr, rd_ptr;
  logic [LVL_WL-1:0] level;
  logic              out_valid;
  cand_t             head;
  logic              ovf_sticky;
  logic [CNT_WL-1:0] drop_cnt;

  logic              pop_c, push_c, drop_c, full_c;
  logic [LVL_WL-1:0] level_nxt_c;
  logic [PTR_WL-1:0] rd_nxt_c;
  cand_t             head_nxt_c;

  // Push/pop decision and look-ahead of the next head entry
  always_comb begin
    pop_c       = out_valid & bus.out_ready;
    full_c      = (level == LVL_WL'(DEPTH));
    push_c      = v2 & (~full_c | pop_c);
    drop_c      = v2 & full_c & ~pop_c;
    level_nxt_c = level;
    if (push_c && !pop_c) begin
      level_nxt_c = level + LVL_WL'(1);
    end else if (pop_c && !push_c) begin
      level_nxt_c = level - LVL_WL'(1);
    end
    rd_nxt_c   = pop_c ? (rd_ptr + PTR_WL'(1)) : rd_ptr;
    // The slot being written this cycle is not yet in mem, forward it
    head_nxt_c = mem[rd_nxt_c];
    if (push_c && (wr_ptr == rd_nxt_c)) begin
      head_nxt_c = s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      head       <= '0;
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= s2;
        wr_ptr      <= wr_ptr + PTR_WL'(1);
      end
      rd_ptr    <= rd_nxt_c;
      level     <= level_nxt_c;
      out_valid <= (level_nxt_c != '0);
      head      <= head_nxt_c;
      // A drop in the same cycle as a clear restarts the count at one
      if (drop_c) begin
        ovf_sticky <= 1'b1;
        if (bus.ovf_clr) begin
          drop_cnt <= CNT_WL'(1);
        end else if (drop_cnt != {CNT_WL{1'b1}}) begin
          drop_cnt <= drop_cnt + CNT_WL'(1);
        end
      end else if (bus.ovf_clr) begin
        ovf_sticky <= 1'b0;
        drop_cnt   <= '0;
      end
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_path   = head.path;
  assign bus.out_ped    = head.ped;
  assign bus.out_idx    = head.idx;
  assign bus.fifo_level = level;
  assign bus.ovf_sticky = ovf_sticky;
  assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_path_decision_out.sv
// Self-checking bench for path_decision_out: directed scenarios plus a long
// randomized stream checked against a queue-based reference model.
module tb_path_decision_out;
  import path_decision_out_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_decision_out_if bus ();

  path_decision_out dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  cand_t q[$];
  bit    m_v1, m_v2;
  cand_t m_c1, m_c2;
  int    m_drop;
  bit    m_sticky;

  // First path with the strictly smallest PED (lower index wins ties)
  function automatic cand_t ref_best(input logic [NUM_PATH*PATH_WL-1:0] paths,
                                     input logic [NUM_PATH*PED_WL-1:0] peds);
    cand_t b;
    b.path = paths[PATH_WL-1:0];
    b.ped  = peds[PED_WL-1:0];
    b.idx  = '0;
    for (int k = 1; k < NUM_PATH; k++) begin
      if (peds[k*PED_WL +: PED_WL] < b.ped) begin
        b.path = paths[k*PATH_WL +: PATH_WL];
        b.ped  = peds[k*PED_WL +: PED_WL];
        b.idx  = IDX_WL'(k);
      end
    end
    return b;
  endfunction

  function automatic logic [NUM_PATH*PED_WL-1:0] pk(input int p0, input int p1,
                                                    input int p2, input int p3);
    return {16'(p3), 16'(p2), 16'(p1), 16'(p0)};
  endfunction

  function automatic logic [NUM_PATH*PED_WL-1:0] rnd_peds();
    logic [NUM_PATH*PED_WL-1:0] p;
    for (int k = 0; k < NUM_PATH; k++) begin
      if ($urandom_range(0, 2) == 0) p[k*PED_WL +: PED_WL] = 16'($urandom_range(0, 3));
      else                           p[k*PED_WL +: PED_WL] = 16'($urandom);
    end
    return p;
  endfunction

  // Model of one clock edge: two-cycle compare latency, then FIFO admission
  function automatic void model_edge();
    bit pop, drop;
    if (!rst) begin
      q.delete();
      m_v1 = 0; m_v2 = 0; m_drop = 0; m_sticky = 0;
      return;
    end
    pop  = (q.size() > 0) && bus.out_ready;
    drop = 0;
    if (m_v2) begin
      if (q.size() < DEPTH || pop) q.push_back(m_c2);
      else drop = 1;
    end
    if (pop) void'(q.pop_front());
    if (drop) begin
      m_sticky = 1;
      m_drop   = bus.ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (bus.ovf_clr) begin
      m_sticky = 0;
      m_drop   = 0;
    end
    m_v2 = m_v1;
    m_c2 = m_c1;
    m_v1 = bus.in_valid;
    m_c1 = ref_best(bus.path_in, bus.ped_in);
  endfunction

  task automatic drive(input logic v, input logic [NUM_PATH*PED_WL-1:0] peds,
                       input logic rdy, input logic clr);
    bus.in_valid  = v;
    bus.path_in   = $urandom;
    bus.ped_in    = peds;
    bus.out_ready = rdy;
    bus.ovf_clr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic cand_t got_head();
    cand_t g;
    g.path = bus.out_path;
    g.ped  = bus.out_ped;
    g.idx  = bus.out_idx;
    return g;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    drive(0, '0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
    n_checks++; if (bus.fifo_level !== '0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", bus.fifo_level); end
    n_checks++; if (bus.drop_cnt !== '0) begin n_errors++; $display("FAIL reset_drop: got %0d expected 0", bus.drop_cnt); end
    n_checks++; if (bus.ovf_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_sticky: got %0b expected 0", bus.ovf_sticky); end
  endtask

  task automatic test_basic();
    logic [PATH_WL-1:0] p1;
    drive(1, pk(40, 12, 30, 25), 1, 0);
    p1 = bus.path_in[PATH_WL +: PATH_WL];
    tick();
    drive(0, '0, 1, 0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_lat1: got %0b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_lat2: got %0b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_lat3: got %0b expected 1", bus.out_valid); end
    n_checks++; if (bus.out_idx !== 2'd1) begin n_errors++; $display("FAIL basic_idx: got %0d expected 1", bus.out_idx); end
    n_checks++; if (bus.out_ped !== 16'd12) begin n_errors++; $display("FAIL basic_ped: got %0d expected 12", bus.out_ped); end
    n_checks++; if (bus.out_path !== p1) begin n_errors++; $display("FAIL basic_path: got %0h expected %0h", bus.out_path, p1); end
    n_checks++; if (bus.fifo_level !== LVL_WL'(1)) begin n_errors++; $display("FAIL basic_level: got %0d expected 1", bus.fifo_level); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_tie();
    drive(1, pk(7, 7, 7, 7), 1, 0);
    tick();
    drive(1, pk(9, 5, 5, 9), 1, 0);
    tick();
    drive(0, '0, 1, 0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd0 || bus.out_ped !== 16'd7) begin
      n_errors++; $display("FAIL tie_all_equal: got v=%0b idx=%0d ped=%0d expected v=1 idx=0 ped=7", bus.out_valid, bus.out_idx, bus.out_ped); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd1 || bus.out_ped !== 16'd5) begin
      n_errors++; $display("FAIL tie_mid_pair: got v=%0b idx=%0d ped=%0d expected v=1 idx=1 ped=5", bus.out_valid, bus.out_idx, bus.out_ped); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL tie_drain: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    cand_t exp [6];
    for (int i = 0; i < 6; i++) begin
      drive(1, rnd_peds(), 0, 0);
      exp[i] = ref_best(bus.path_in, bus.ped_in);
      tick();
    end
    drive(0, '0, 0, 0);
    tick();
    tick();
    n_checks++; if (bus.fifo_level !== LVL_WL'(4)) begin n_errors++; $display("FAIL ovf_level: got %0d expected 4", bus.fifo_level); end
    n_checks++; if (bus.drop_cnt !== 8'd2) begin n_errors++; $display("FAIL ovf_drop: got %0d expected 2", bus.drop_cnt); end
    n_checks++; if (bus.ovf_sticky !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %0b expected 1", bus.ovf_sticky); end
    drive(0, '0, 0, 1);
    tick();
    drive(0, '0, 1, 0);
    n_checks++; if (bus.drop_cnt !== 8'd0 || bus.ovf_sticky !== 1'b0) begin
      n_errors++; $display("FAIL ovf_clear: got cnt=%0d sticky=%0b expected 0 0", bus.drop_cnt, bus.ovf_sticky); end
    n_checks++; if (bus.fifo_level !== LVL_WL'(4)) begin n_errors++; $display("FAIL ovf_clear_level: got %0d expected 4", bus.fifo_level); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || got_head() !== exp[i]) begin
        n_errors++; $display("FAIL ovf_order%0d: got v=%0b %0h expected %0h", i, bus.out_valid, got_head(), exp[i]); end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== '0) begin
      n_errors++; $display("FAIL ovf_empty: got v=%0b level=%0d expected 0 0", bus.out_valid, bus.fifo_level); end
  endtask

  task automatic test_full_push_pop();
    cand_t exp [6];
    for (int i = 0; i < 6; i++) begin
      drive(1, rnd_peds(), 0, 0);
      exp[i] = ref_best(bus.path_in, bus.ped_in);
      tick();
    end
    // The 5th and 6th results arrive at a full FIFO while the head is popped
    drive(0, '0, 1, 0);
    tick();
    n_checks++; if (bus.fifo_level !== LVL_WL'(4)) begin n_errors++; $display("FAIL fpp_level1: got %0d expected 4", bus.fifo_level); end
    n_checks++; if (got_head() !== exp[1]) begin n_errors++; $display("FAIL fpp_head1: got %0h expected %0h", got_head(), exp[1]); end
    tick();
    n_checks++; if (bus.fifo_level !== LVL_WL'(4)) begin n_errors++; $display("FAIL fpp_level2: got %0d expected 4", bus.fifo_level); end
    n_checks++; if (bus.drop_cnt !== 8'd0 || bus.ovf_sticky !== 1'b0) begin
      n_errors++; $display("FAIL fpp_nodrop: got cnt=%0d sticky=%0b expected 0 0", bus.drop_cnt, bus.ovf_sticky); end
    for (int i = 2; i < 6; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || got_head() !== exp[i]) begin
        n_errors++; $display("FAIL fpp_order%0d: got v=%0b %0h expected %0h", i, bus.out_valid, got_head(), exp[i]); end
      tick();
    end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL fpp_empty: got %0b expected 0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 262; i++) begin
      drive(1, rnd_peds(), 0, 0);
      tick();
    end
    drive(0, '0, 0, 0);
    tick();
    tick();
    n_checks++; if (bus.drop_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_drop: got %0d expected 255", bus.drop_cnt); end
    n_checks++; if (bus.fifo_level !== LVL_WL'(4) || bus.ovf_sticky !== 1'b1) begin
      n_errors++; $display("FAIL sat_state: got level=%0d sticky=%0b expected 4 1", bus.fifo_level, bus.ovf_sticky); end
  endtask

  task automatic test_reset_midflight();
    cand_t e;
    drive(0, '0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, rnd_peds(), 0, 0);
      tick();
    end
    drive(0, '0, 0, 0);
    n_checks++; if (bus.fifo_level !== LVL_WL'(3)) begin n_errors++; $display("FAIL rstm_pre_level: got %0d expected 3", bus.fifo_level); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.fifo_level !== '0 || bus.drop_cnt !== '0 || bus.ovf_sticky !== 1'b0) begin
      n_errors++; $display("FAIL rstm_cleared: got v=%0b level=%0d cnt=%0d sticky=%0b expected all 0",
                           bus.out_valid, bus.fifo_level, bus.drop_cnt, bus.ovf_sticky); end
    drive(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rstm_inflight%0d: got %0b expected 0", i, bus.out_valid); end
    end
    drive(1, pk(100, 50, 50, 3), 1, 0);
    e = ref_best(bus.path_in, bus.ped_in);
    tick();
    drive(0, '0, 1, 0);
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL rstm_lat2: got %0b expected 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd3 || bus.out_ped !== 16'd3 || got_head() !== e) begin
      n_errors++; $display("FAIL rstm_after: got v=%0b %0h expected v=1 %0h", bus.out_valid, got_head(), e); end
    tick();
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc  = 0;
    while (sent < 10000 || cyc < DEPTH + 4) begin
      if (sent < 10000) begin
        drive(logic'($urandom_range(0, 9) < 7), rnd_peds(), logic'($urandom_range(0, 9) < 6),
              logic'($urandom_range(0, 63) == 0));
        if (bus.in_valid) sent++;
      end else begin
        drive(0, '0, 1, 0);
        cyc++;
      end
      tick();
      n_checks++; if (bus.out_valid !== (q.size() != 0)) begin
        n_errors++; $display("FAIL rnd_valid: got %0b expected %0b", bus.out_valid, q.size() != 0); end
      n_checks++; if (bus.fifo_level !== LVL_WL'(q.size())) begin
        n_errors++; $display("FAIL rnd_level: got %0d expected %0d", bus.fifo_level, q.size()); end
      n_checks++; if (bus.drop_cnt !== CNT_WL'(m_drop) || bus.ovf_sticky !== m_sticky) begin
        n_errors++; $display("FAIL rnd_ovf: got cnt=%0d sticky=%0b expected %0d %0b", bus.drop_cnt, bus.ovf_sticky, m_drop, m_sticky); end
      if (q.size() != 0 && bus.out_valid === 1'b1) begin
        n_checks++; if (got_head() !== q[0]) begin
          n_errors++; $display("FAIL rnd_data: got %0h expected %0h", got_head(), q[0]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, '0, 0, 0);
    test_reset();
    test_basic();
    test_tie();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
